// File: rtl/key_scan_pkg.sv
// key_scan_pkg: shared scan states, event type and matrix widths for the key scanner
package key_scan_pkg;
    localparam int KS_ROWS   = 4;
    localparam int KS_COLS   = 4;
    localparam int KS_KEYS   = KS_ROWS * KS_COLS;
    localparam int KS_CODE_W = $clog2(KS_KEYS);
    typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, NEXT} scan_state_t;
    typedef struct packed {
        logic [KS_CODE_W-1:0] code;
        logic                 pressed;
    } key_event_t;
endpackage

// File: rtl/key_scan_controller_fifo.sv
// key_event_fifo: synchronous key event queue; accepts a push while full when the head is popped in the same cycle
// ports: clk, rst (async high), push/wr_data in, pop in, rd_data (head, zero when empty), full, empty
module key_event_fifo
    import key_scan_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  key_event_t wr_data,
    input  logic       pop,
    output key_event_t rd_data,
    output logic       full,
    output logic       empty
);
    localparam int PTR_W = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    key_event_t       mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;
    assign full    = int'(count_q) == DEPTH;
    assign empty   = count_q == '0;
    assign rd_data = empty ? '0 : mem_q[rd_ptr_q];
    always_comb begin
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wr_data;
    end
endmodule

// File: rtl/key_scan_controller.sv
// key_scan_controller: column-at-a-time key matrix scanner with per-key debounce and an event queue
// ports: clk, rst (async high), enable; col_drive (one-hot) out, row_sense in;
//        ev_valid/ev_ready/ev_code/ev_pressed event stream; stall (sticky) with clear_stall
module key_scan_controller
    import key_scan_pkg::*;
#(
    parameter int ROWS           = KS_ROWS,
    parameter int COLS           = KS_COLS,
    parameter int SETTLE_CYCLES  = 4,
    parameter int DEBOUNCE_SCANS = 3,
    parameter int FIFO_DEPTH     = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    output logic [COLS-1:0]               col_drive,
    input  logic [ROWS-1:0]               row_sense,
    output logic                          ev_valid,
    input  logic                          ev_ready,
    output logic [$clog2(ROWS*COLS)-1:0]  ev_code,
    output logic                          ev_pressed,
    output logic                          stall,
    input  logic                          clear_stall
);
    localparam int KEYS   = ROWS * COLS;
    localparam int CODE_W = $clog2(KEYS);
    localparam int ROW_W  = ROWS > 1 ? $clog2(ROWS) : 1;
    localparam int COL_W  = COLS > 1 ? $clog2(COLS) : 1;
    localparam int SET_W  = SETTLE_CYCLES > 1 ? $clog2(SETTLE_CYCLES) : 1;
    localparam int CNT_W  = $clog2(DEBOUNCE_SCANS + 1);
    scan_state_t       state_q, state_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [SET_W-1:0]  settle_q, settle_d;
    logic [KEYS-1:0]   stable_q, stable_d;
    logic [CNT_W-1:0]  cnt_q [KEYS];
    logic [CNT_W-1:0]  cnt_d [KEYS];
    logic              stall_q, stall_d;
    logic [CODE_W-1:0] key;
    logic              raw, push, full, empty;
    key_event_t        push_ev, head;
    key_event_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .push   (push),
        .wr_data(push_ev),
        .pop    (ev_ready),
        .rd_data(head),
        .full   (full),
        .empty  (empty)
    );
    assign col_drive  = (state_q == DRIVE || state_q == SAMPLE) ? COLS'(1) << col_q : '0;
    assign ev_valid   = !empty;
    assign ev_code    = head.code;
    assign ev_pressed = head.pressed;
    assign stall      = stall_q;
    // enable is only consulted in IDLE and NEXT so a started column always finishes
    always_comb begin
        state_d  = state_q;
        col_d    = col_q;
        row_d    = row_q;
        settle_d = settle_q;
        unique case (state_q)
            IDLE: begin
                state_d  = enable ? DRIVE : IDLE;
                settle_d = '0;
            end
            DRIVE: begin
                settle_d = settle_q + 1'b1;
                if (int'(settle_q) == SETTLE_CYCLES - 1) begin
                    state_d  = SAMPLE;
                    row_d    = '0;
                    settle_d = '0;
                end
            end
            SAMPLE: begin
                row_d   = row_q + 1'b1;
                state_d = int'(row_q) == ROWS - 1 ? NEXT : SAMPLE;
            end
            NEXT: begin
                col_d    = int'(col_q) == COLS - 1 ? '0 : col_q + 1'b1;
                state_d  = enable ? DRIVE : IDLE;
                settle_d = '0;
            end
            default: state_d = IDLE;
        endcase
    end
    // a commit blocked by a full queue leaves the key untouched so it retries next scan
    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        push     = 1'b0;
        stall_d  = clear_stall ? 1'b0 : stall_q;
        key      = CODE_W'(int'(col_q) * ROWS + int'(row_q));
        raw      = row_sense[row_q];
        push_ev  = '{code: key, pressed: raw};
        if (state_q == SAMPLE) begin
            if (raw == stable_q[key]) cnt_d[key] = '0;
            else if (int'(cnt_q[key]) + 1 < DEBOUNCE_SCANS) cnt_d[key] = cnt_q[key] + 1'b1;
            else if (full && !(ev_valid && ev_ready)) stall_d = 1'b1;
            else begin
                stable_d[key] = raw;
                cnt_d[key]    = '0;
                push          = 1'b1;
            end
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            col_q    <= '0;
            row_q    <= '0;
            settle_q <= '0;
            stable_q <= '0;
            stall_q  <= 1'b0;
            for (int i = 0; i < KEYS; i++) cnt_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            col_q    <= col_d;
            row_q    <= row_d;
            settle_q <= settle_d;
            stable_q <= stable_d;
            stall_q  <= stall_d;
            cnt_q    <= cnt_d;
        end
    end
endmodule

// File: tb/tb_key_scan_controller.sv
// tb_key_scan_controller: frame-level reference model of the scanner checked against the design
module tb_key_scan_controller;
    typedef struct {
        int code;
        bit pressed;
        int t;
    } ev_t;
    logic        clk = 1'b0;
    logic        rst, enable, ev_ready, clear_stall;
    logic [3:0]  col_drive, row_sense, ev_code;
    logic        ev_valid, ev_pressed, stall;
    logic [15:0] held;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    ev_t         got[$];
    ev_t         exp_q[$];
    ev_t         backlog[$];
    bit          mstable[16];
    int          mcnt[16];
    bit          mstall;
    int          last_vis;
    key_scan_controller dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .col_drive  (col_drive),
        .row_sense  (row_sense),
        .ev_valid   (ev_valid),
        .ev_ready   (ev_ready),
        .ev_code    (ev_code),
        .ev_pressed (ev_pressed),
        .stall      (stall),
        .clear_stall(clear_stall)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always_comb begin
        row_sense = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                if (col_drive[c] && held[c*4+r]) row_sense[r] = 1'b1;
    end
    always @(negedge clk) begin
        if (!rst && ev_valid && ev_ready) got.push_back('{int'(ev_code), ev_pressed, cyc});
    end
    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask
    task automatic model_reset();
        for (int k = 0; k < 16; k++) begin
            mstable[k] = 1'b0;
            mcnt[k]    = 0;
        end
        backlog.delete();
        exp_q.delete();
        got.delete();
        last_vis = 0;
        mstall   = 1'b0;
    endtask
    // One 36-cycle frame: keys are read once each in column-then-row order;
    // a key needs 3 consecutive disagreeing reads, and a full queue defers it.
    task automatic run_frame(input bit chk_cols);
        int  fbase;
        int  t;
        ev_t e;
        fbase = cyc;
        if (ev_ready) begin
            if (last_vis < fbase - 1) last_vis = fbase - 1;
            while (backlog.size() > 0) begin
                e = backlog.pop_front();
                last_vis++;
                e.t = last_vis;
                exp_q.push_back(e);
            end
        end
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                int k;
                k = c * 4 + r;
                t = fbase + 9 * c + 4 + r;
                if (held[k] == mstable[k]) mcnt[k] = 0;
                else if (mcnt[k] + 1 < 3) mcnt[k]++;
                else if (!ev_ready && backlog.size() >= 8) mstall = 1'b1;
                else begin
                    mstable[k] = held[k];
                    mcnt[k]    = 0;
                    e = '{k, held[k], 0};
                    if (ev_ready) begin
                        e.t      = (t + 1 > last_vis + 1) ? t + 1 : last_vis + 1;
                        last_vis = e.t;
                        exp_q.push_back(e);
                    end else backlog.push_back(e);
                end
            end
        end
        for (int i = 0; i < 36; i++) begin
            if (chk_cols) chk("col_drive", col_drive, (i % 9 == 8) ? 0 : 1 << (i / 9));
            @(posedge clk);
            #1;
        end
    endtask
    task automatic frames(input int n);
        for (int i = 0; i < n; i++) run_frame(1'b0);
    endtask
    task automatic check_events(input string tag);
        chk({tag, " count"}, got.size(), exp_q.size());
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            chk({tag, " code"}, got[i].code, exp_q[i].code);
            chk({tag, " pressed"}, got[i].pressed, exp_q[i].pressed);
            chk({tag, " time"}, got[i].t, exp_q[i].t);
        end
        got.delete();
        exp_q.delete();
    endtask
    initial begin
        rst = 1'b1;
        enable = 1'b1;
        ev_ready = 1'b1;
        clear_stall = 1'b0;
        held = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst col_drive", col_drive, 0);
        chk("rst ev_valid", ev_valid, 0);
        chk("rst ev_code", ev_code, 0);
        chk("rst ev_pressed", ev_pressed, 0);
        chk("rst stall", stall, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        run_frame(1'b1);
        run_frame(1'b1);
        check_events("idle");
        held = 16'h0200;
        frames(3);
        check_events("press9");
        held = '0;
        frames(3);
        check_events("release9");
        held = 16'h0200;
        frames(2);
        held = '0;
        frames(1);
        held = 16'h0200;
        frames(2);
        check_events("bounce");
        frames(1);
        check_events("bounce_late");
        held = '0;
        frames(3);
        check_events("bounce_release");
        held = 16'h0090;
        frames(3);
        check_events("keys4_7");
        held = '0;
        frames(3);
        check_events("keys4_7_release");
        for (int i = 0; i < 16; i++) begin
            if ($urandom_range(0, 2) == 0) held = 16'($urandom & $urandom & $urandom);
            run_frame(1'b0);
        end
        held = '0;
        frames(3);
        check_events("random");
        ev_ready = 1'b0;
        held = 16'h01FF;
        frames(3);
        chk("full stall", stall, mstall);
        chk("full ev_valid", ev_valid, 1);
        chk("full head code", ev_code, 0);
        chk("full head pressed", ev_pressed, 1);
        check_events("full_hold");
        ev_ready = 1'b1;
        frames(1);
        check_events("drain");
        chk("drain stall", stall, mstall);
        clear_stall = 1'b1;
        mstall = 1'b0;
        frames(1);
        clear_stall = 1'b0;
        chk("cleared stall", stall, mstall);
        held = '0;
        frames(3);
        check_events("full_release");
        ev_ready = 1'b0;
        held = 16'h0007;
        frames(3);
        chk("queued ev_valid", ev_valid, 1);
        repeat (19) @(posedge clk);
        #1;
        chk("pre_rst col_drive", col_drive, 4'b0100);
        #2;
        rst = 1'b1;
        #1;
        chk("async col_drive", col_drive, 0);
        chk("async ev_valid", ev_valid, 0);
        chk("async stall", stall, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        ev_ready = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        frames(2);
        check_events("post_rst_early");
        frames(1);
        check_events("post_rst");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/key_scan_controller.md
Name: key_scan_controller

Overview:
Sequences the custom keyboard's switch matrix. Drives one column at a time, waits a settle time, then samples each row. Each key is debounced across scans, and press/release events are queued into a small event FIFO. The downstream Keyboard datapath consumes events over a valid/ready handshake as its key input stream.

Parameters:
ROWS, 4, number of row sense lines
COLS, 4, number of column drive lines
SETTLE_CYCLES, 4, cycles a column is driven before its first row sample (>=1)
DEBOUNCE_SCANS, 3, consecutive disagreeing scans needed to accept a key change (>=1)
FIFO_DEPTH, 8, event queue entries (power of two)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-high reset
enable  input  1  scanning enabled
col_drive  output  COLS  one-hot active-high column drive
row_sense  input  ROWS  raw row inputs, high = switch closed on driven column
ev_valid  output  1  event available
ev_ready  input  1  consumer accepts event
ev_code  output  $clog2(ROWS*COLS)  key code = col*ROWS + row
ev_pressed  output  1  1 = press, 0 = release
stall  output  1  sticky: a debounced change was held back because the FIFO was full
clear_stall  input  1  synchronous clear of stall

Behaviour:
- Clock and reset: one clock, clk; reset rst is asynchronous, active-high.
- Reset values:
  - col_drive=0, ev_valid=0, ev_code=0, ev_pressed=0, stall=0.
  - All stable key states = released; all debounce counters = 0; FIFO empty.
  - FSM in IDLE; column index 0.
- FSM states:
  - IDLE: col_drive=0. Go to DRIVE when enable=1.
  - DRIVE: col_drive=1<<col. Settle counter runs 0..SETTLE_CYCLES-1, then go to SAMPLE with row=0.
  - SAMPLE: one row evaluated per cycle, col_drive held. After row ROWS-1, go to NEXT.
  - NEXT (1 cycle): col_drive=0 and col wraps COLS-1 -> 0. Go to DRIVE if enable=1, else IDLE.
  - enable deassertion takes effect only at NEXT; a column in progress always completes.
- Scan timing:
  - One column takes SETTLE_CYCLES+ROWS+1 cycles; one frame takes COLS times that.
  - Defaults: 9 cycles per column, 36 cycles per frame.
- Per-key debounce, for the sampled key k:
  - raw==stable[k]: cnt[k] <= 0.
  - raw!=stable[k] and cnt[k]+1 < DEBOUNCE_SCANS: cnt[k] increments.
  - raw!=stable[k] and cnt[k]+1 == DEBOUNCE_SCANS: commit. stable[k] flips, cnt[k] <= 0, and event {k, new stable} is pushed.
  - Counter width is $clog2(DEBOUNCE_SCANS+1); it never wraps.
- FIFO full at the commit point:
  - If full and no pop this cycle: commit is suppressed, stable[k] and cnt[k] are unchanged, stall <= 1. The change retries on the next scan, so no event is lost.
  - If full and a pop occurs in the same cycle: the push is accepted.
- Event output:
  - A pushed event is visible on ev_valid/ev_code/ev_pressed the cycle after the push.
  - ev_code and ev_pressed stay stable while ev_valid=1 and ev_ready=0.
  - Pop happens when ev_valid && ev_ready.
  - FIFO order follows scan order (column ascending, then row ascending).
- stall:
  - clear_stall clears it.
  - If a set and a clear occur in the same cycle, the set wins.
- Reset mid-operation: all state, including queued events, returns to reset values immediately (asynchronous).

Decomposition:
- Package key_scan_pkg holds:
  - scan_state_t enum (IDLE, DRIVE, SAMPLE, NEXT).
  - key_event_t packed struct {code, pressed}.
  - Width localparams derived from ROWS/COLS.
- Sub-module key_event_fifo: synchronous FIFO of key_event_t, depth FIFO_DEPTH, with push/pop/full/empty. Same-cycle push on full is allowed when a pop occurs.

Test Plan:
- Reset, enable=1, no keys pressed:
  - col_drive cycles 0001, 0010, 0100, 1000, each column lasting 9 cycles with 1 of those cycles at zero (NEXT).
  - Frame period is 36 cycles; ev_valid never asserts.
- Key row1/col2 held closed (code 9), ev_ready=1:
  - Exactly one event {9, pressed=1}, appearing 1 cycle after the 3rd disagreeing sample.
  - Releasing the key yields exactly one {9, pressed=0} after 3 more scans.
- Bounce, code 9 closed for 2 scans then open: no event; cnt returns to 0.
- Codes 4 and 7 (col1, rows 0 and 3) closed together: events 4 then 7 in the same frame, 3 cycles apart.
- ev_ready=0 and 9 keys pressed:
  - FIFO holds 8 events; the 9th is suppressed and stall=1.
  - Raise ev_ready: the 8 events drain in order, then the 9th event appears on a following scan.
  - clear_stall returns stall to 0.
- Reset mid-operation, rst asserted with 3 events queued and column 2 driven:
  - Immediately col_drive=0, ev_valid=0, stall=0.
  - After rst drops with keys still held, the first new events appear only after 3 full scans.
